// File: rtl/btn_conditioner.sv
// Pushbutton front end: two-flop synchroniser and debounce counter per button,
// stable levels for left/right/down and single-cycle press pulses for centre/up.

module btn_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s;
    logic             st;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= raw;
            s  <= s1;
        end
    end

    // Any sample that agrees with the debounced state restarts the count,
    // so st only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= 1'b0;
            cnt <= '0;
        end else if (s == st) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            st  <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign level = st;

endmodule

module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

module btn_conditioner #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnl_raw,
    input  logic btnr_raw,
    input  logic btnd_raw,
    input  logic btnc_raw,
    input  logic btnu_raw,
    output logic btnl,
    output logic btnr,
    output logic btnd,
    output logic btnc_pulse,
    output logic btnu_pulse
);

    // Bit order: {up, centre, down, right, left}.
    logic [4:0] raw_vec;
    logic [4:0] lvl;

    assign raw_vec = {btnu_raw, btnc_raw, btnd_raw, btnr_raw, btnl_raw};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[i]),
            .level (lvl[i])
        );
    end

    assign btnl = lvl[0];
    assign btnr = lvl[1];
    assign btnd = lvl[2];

    btn_pulse u_pulse_c (
        .clk   (clk),
        .rst_n (rst_n),
        .level (lvl[3]),
        .pulse (btnc_pulse)
    );

    btn_pulse u_pulse_u (
        .clk   (clk),
        .rst_n (rst_n),
        .level (lvl[4]),
        .pulse (btnu_pulse)
    );

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: a DB_CYCLES=4 and a DB_CYCLES=1 instance share
// stimulus; a sample-window reference model feeds a per-cycle scoreboard.

module tb_btn_conditioner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btnl_raw = 1'b0, btnr_raw = 1'b0, btnd_raw = 1'b0, btnc_raw = 1'b0, btnu_raw = 1'b0;
    logic btnl, btnr, btnd, btnc_pulse, btnu_pulse;
    logic btnl_1, btnr_1, btnd_1, btnc_pulse_1, btnu_pulse_1;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    logic [4:0] hist[$];
    logic       st_m[2][5];
    logic       rose_m[2][5];
    int         last_flip[2][5];
    int         db_of[2] = '{4, 1};

    always #5 clk = ~clk;

    btn_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnl_raw   (btnl_raw),
        .btnr_raw   (btnr_raw),
        .btnd_raw   (btnd_raw),
        .btnc_raw   (btnc_raw),
        .btnu_raw   (btnu_raw),
        .btnl       (btnl),
        .btnr       (btnr),
        .btnd       (btnd),
        .btnc_pulse (btnc_pulse),
        .btnu_pulse (btnu_pulse)
    );

    btn_conditioner #(.DB_CYCLES(1), .CNT_W(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnl_raw   (btnl_raw),
        .btnr_raw   (btnr_raw),
        .btnd_raw   (btnd_raw),
        .btnc_raw   (btnc_raw),
        .btnu_raw   (btnu_raw),
        .btnl       (btnl_1),
        .btnr       (btnr_1),
        .btnd       (btnd_1),
        .btnc_pulse (btnc_pulse_1),
        .btnu_pulse (btnu_pulse_1)
    );

    function automatic logic [9:0] obs_vec();
        return {btnu_pulse_1, btnc_pulse_1, btnd_1, btnr_1, btnl_1,
                btnu_pulse, btnc_pulse, btnd, btnr, btnl};
    endfunction

    function automatic logic get_out(input int sel);
        logic [9:0] v;
        v = obs_vec();
        return v[sel];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Synchronised sample seen by the debounce logic at post-reset edge k.
    function automatic logic s_at(input int k, input int b);
        if (k < 2) return 1'b0;
        return hist[k-2][b];
    endfunction

    // Reference: a level flips once DB samples in a row, all taken after the
    // previous flip, disagree with it; a pulse follows a rising flip by one edge.
    task automatic model_step();
        int   n;
        logic differ;
        logic pulse_prev;
        logic [9:0] e;
        if (!rst_n) begin
            hist.delete();
            for (int d = 0; d < 2; d++)
                for (int b = 0; b < 5; b++) begin
                    st_m[d][b]      = 1'b0;
                    rose_m[d][b]    = 1'b0;
                    last_flip[d][b] = -1;
                end
            return;
        end
        hist.push_back({btnu_raw, btnc_raw, btnd_raw, btnr_raw, btnl_raw});
        n = hist.size() - 1;
        e = '0;
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 5; b++) begin
                pulse_prev = rose_m[d][b];
                differ = ((n - last_flip[d][b]) >= db_of[d]);
                for (int j = 0; j < db_of[d]; j++)
                    if (s_at(n - j, b) == st_m[d][b]) differ = 1'b0;
                rose_m[d][b] = differ & ~st_m[d][b];
                if (differ) begin
                    st_m[d][b]      = ~st_m[d][b];
                    last_flip[d][b] = n;
                end
                e[d*5+b] = (b < 3) ? st_m[d][b] : pulse_prev;
            end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_outputs", 32'(obs_vec()), 32'h0);
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("scoreboard", 32'(obs_vec()), 32'(exp_v));
        end
    end

    task automatic set_raw(input logic [4:0] v);
        {btnu_raw, btnc_raw, btnd_raw, btnr_raw, btnl_raw} = v;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Edges until output sel reaches target; 0 when the bound runs out.
    task automatic edges_until(input int sel, input logic target, input int limit, output int k);
        k = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #2;
            if (get_out(sel) === target) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k, first_c, cnt_c, cnt_u, bad, first4, first1, cnt4, cnt1;
        logic [2:0] lvl;

        // Reset with every button held, then btnl latency from release.
        set_raw(5'b11111);
        step(4);
        rst_n = 1'b1;
        set_raw(5'b00001);
        edges_until(0, 1'b1, 20, k);
        chk("btnl_rise_edges", k, 6);

        // Bounce on btnr: two-cycle holds never reach the debounce count.
        set_raw(5'b00011); step(2); chk("btnr_bounce_a", btnr, 0);
        set_raw(5'b00001); step(2); chk("btnr_bounce_b", btnr, 0);
        set_raw(5'b00011); step(2); chk("btnr_bounce_c", btnr, 0);
        set_raw(5'b00001); step(2); chk("btnr_bounce_d", btnr, 0);
        set_raw(5'b00011);
        edges_until(1, 1'b1, 20, k);
        chk("btnr_rise_edges", k, 6);

        // Release debounce on btnd.
        set_raw(5'b00111); step(10);
        chk("btnd_pressed", btnd, 1);
        set_raw(5'b00011); step(3);
        set_raw(5'b00111); step(10);
        chk("btnd_glitch_held", btnd, 1);
        set_raw(5'b00011);
        edges_until(2, 1'b0, 20, k);
        chk("btnd_fall_edges", k, 6);

        // Execute pulse: one pulse per debounced press, none on release.
        set_raw(5'b00000); step(15);
        first_c = 0; cnt_c = 0; cnt_u = 0;
        set_raw(5'b01000);
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (btnc_pulse) begin
                cnt_c++;
                if (first_c == 0) first_c = i;
            end
            if (btnu_pulse) cnt_u++;
        end
        chk("btnc_pulse_edge", first_c, 7);
        chk("btnc_pulse_count1", cnt_c, 1);
        cnt_c = 0;
        set_raw(5'b00000);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (btnc_pulse) cnt_c++;
            if (btnu_pulse) cnt_u++;
        end
        chk("btnc_no_release_pulse", cnt_c, 0);
        set_raw(5'b01000);
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (btnc_pulse) cnt_c++;
            if (btnu_pulse) cnt_u++;
        end
        chk("btnc_pulse_count2", cnt_c, 1);
        chk("btnu_quiet", cnt_u, 0);
        set_raw(5'b00000); step(20);

        // Simultaneous levels: encoder sees 000 then 111, nothing between.
        bad = 0; k = 0;
        set_raw(5'b00111);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            lvl = {btnd, btnr, btnl};
            if (lvl != 3'b000 && lvl != 3'b111) bad++;
            if (lvl == 3'b111) begin
                k = i;
                break;
            end
        end
        chk("lrd_rise_edges", k, 6);
        chk("lrd_no_transient", bad, 0);
        set_raw(5'b00000); step(20);

        // Reset mid-count on btnu, for both debounce lengths.
        set_raw(5'b10000); step(3);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1;
        first4 = 0; first1 = 0; cnt4 = 0; cnt1 = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (btnu_pulse) begin
                cnt4++;
                if (first4 == 0) first4 = i;
            end
            if (btnu_pulse_1) begin
                cnt1++;
                if (first1 == 0) first1 = i;
            end
        end
        chk("btnu_pulse_edge_db4", first4, 7);
        chk("btnu_pulse_count_db4", cnt4, 1);
        chk("btnu_pulse_edge_db1", first1, 4);
        chk("btnu_pulse_count_db1", cnt1, 1);
        set_raw(5'b00000); step(20);

        // Random button activity with occasional resets, scoreboard-checked.
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                step($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            set_raw(5'($urandom_range(0, 31)));
            step($urandom_range(1, 9));
        end
        set_raw(5'b00000);
        step(20);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
